sec_timer_sched: RTL

- Shared 1 Hz timebase plus NUM_CH independent countdown channels, each counting whole ticks.
- One free-running prescaler drives all channels, so they share a single divider instead of each instantiating its own.
- Channels are loaded, stopped, paused and resumed through a command handshake.
- Expiry events are queued per channel and drained through a round-robin valid/ready port.

---
 rtl/sec_timer_sched.sv | 283 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/sec_timer_sched.sv
// sec_timer_sched: one shared tick prescaler feeding NUM_CH whole-tick
// countdown channels. Channels are controlled through a valid/ready command
// port; expiries are latched as pending flags and drained one at a time
// through a round-robin valid/ready done port.
// Optional feature: define SEC_TIMER_SQWAVE_EN to add the sq_out square wave.

module sec_timer_sched #(
    parameter int unsigned TICK_DIV = 100000000,
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [1:0]                cmd_op,
    input  logic [$clog2(NUM_CH)-1:0] cmd_ch,
    input  logic [CNT_W-1:0]          cmd_val,
    output logic                      tick,
`ifdef SEC_TIMER_SQWAVE_EN
    output logic                      sq_out,
`endif
    output logic [NUM_CH-1:0]         ch_busy,
    output logic                      done_valid,
    output logic [$clog2(NUM_CH)-1:0] done_ch,
    input  logic                      done_ready
);

    localparam int unsigned     CH_W    = $clog2(NUM_CH);
    localparam int unsigned     PS_W    = $clog2(TICK_DIV);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);
    localparam logic [CH_W-1:0] CH_LAST = CH_W'(NUM_CH - 1);

    typedef enum logic [1:0] {
        OP_LOAD   = 2'b00,
        OP_STOP   = 2'b01,
        OP_PAUSE  = 2'b10,
        OP_RESUME = 2'b11
    } cmd_op_e;

    typedef enum logic [1:0] {
        CH_IDLE   = 2'b00,
        CH_RUN    = 2'b01,
        CH_PAUSED = 2'b10
    } ch_state_e;

    // Prescaler and tick
    logic [PS_W-1:0]  presc_q, presc_d;
    logic             tick_q, tick_d;

    // Per-channel state
    ch_state_e        state_q [NUM_CH];
    ch_state_e        state_d [NUM_CH];
    logic [CNT_W-1:0] rem_q   [NUM_CH];
    logic [CNT_W-1:0] rem_d   [NUM_CH];

    // Expiry flags
    logic [NUM_CH-1:0] pending_q, pending_d;
    logic [NUM_CH-1:0] pend_set, pend_clr;

    // Command handshake
    logic              cmd_fire;

    // Done arbiter
    logic              done_valid_q, done_valid_d;
    logic [CH_W-1:0]   done_ch_q, done_ch_d;
    logic [CH_W-1:0]   rr_q, rr_d;
    logic              done_accept;
    logic [NUM_CH-1:0] avail;
    logic [CH_W-1:0]   start;
    logic              sel_hi_valid, sel_lo_valid;
    logic [CH_W-1:0]   sel_hi, sel_lo;

    // ------------------------------------------------------------------
    // Prescaler next state: wrap at TICK_DIV-1, tick follows one cycle later
    // NOTE: every signal written in an always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        presc_d = (presc_q == PS_LAST) ? '0 : presc_q + PS_W'(1);
        tick_d  = (presc_q == PS_LAST);
    end

    // Prescaler and tick registers, free-running regardless of commands
    // NOTE: sequential state uses non-blocking <= so every flop samples the
    // pre-edge values no matter how the blocks are ordered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            tick_q  <= tick_d;
        end
    end

    assign tick = tick_q;

    // ------------------------------------------------------------------
    // Commands are held off while the addressed channel has an unread expiry
    always_comb begin
        cmd_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cmd_ch == CH_W'(i) && pending_q[i]) begin
                cmd_ready = 1'b0;
            end
        end
    end

    assign cmd_fire = cmd_valid && cmd_ready;

    // Channel next state: an accepted command beats a same-cycle tick
    always_comb begin
        pend_set = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i] = state_q[i];
            rem_d[i]   = rem_q[i];
            if (cmd_fire && cmd_ch == CH_W'(i)) begin
                case (cmd_op_e'(cmd_op))
                    OP_LOAD: begin
                        if (cmd_val != '0) begin
                            state_d[i] = CH_RUN;
                            rem_d[i]   = cmd_val;
                        end else begin
                            state_d[i]  = CH_IDLE;
                            rem_d[i]    = '0;
                            pend_set[i] = 1'b1;
                        end
                    end
                    OP_STOP: begin
                        state_d[i] = CH_IDLE;
                        rem_d[i]   = '0;
                    end
                    OP_PAUSE: begin
                        if (state_q[i] == CH_RUN) begin
                            state_d[i] = CH_PAUSED;
                        end
                    end
                    OP_RESUME: begin
                        if (state_q[i] == CH_PAUSED) begin
                            state_d[i] = CH_RUN;
                        end
                    end
                    default: ;
                endcase
            end else if (tick_q && state_q[i] == CH_RUN) begin
                // Last tick expires the channel; remaining never goes below 0
                if (rem_q[i] <= CNT_W'(1)) begin
                    state_d[i]  = CH_IDLE;
                    rem_d[i]    = '0;
                    pend_set[i] = 1'b1;
                end else begin
                    rem_d[i] = rem_q[i] - CNT_W'(1);
                end
            end
        end
    end

    // Channel state and remaining-count registers
    // NOTE: the per-channel arrays are a handful of flops, not a RAM, so they
    // are reset in full; a true memory macro would not be reset this way.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= CH_IDLE;
                rem_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= state_d[i];
                rem_q[i]   <= rem_d[i];
            end
        end
    end

    // A channel is busy whenever it is running or paused
    always_comb begin
        ch_busy = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_busy[i] = (state_q[i] != CH_IDLE);
        end
    end

    // ------------------------------------------------------------------
    assign done_accept = done_valid_q && done_ready;

    // Pending flags: accepted event clears, a new expiry sets, set wins
    always_comb begin
        pend_clr = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (done_accept && done_ch_q == CH_W'(i)) begin
                pend_clr[i] = 1'b1;
            end
        end
        pending_d = (pending_q & ~pend_clr) | pend_set;
    end

    // Round-robin pick: first registered pending flag at or after the
    // pointer; the presented channel is held until it is accepted.
    always_comb begin
        done_valid_d = done_valid_q;
        done_ch_d    = done_ch_q;
        rr_d         = rr_q;
        avail        = pending_q;
        start        = rr_q;
        sel_hi_valid = 1'b0;
        sel_lo_valid = 1'b0;
        sel_hi       = '0;
        sel_lo       = '0;

        if (done_accept) begin
            avail = pending_q & ~pend_clr;
            start = (done_ch_q == CH_LAST) ? '0 : done_ch_q + CH_W'(1);
            rr_d  = start;
        end

        // Scan downwards so the lowest index in each half wins
        for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
            if (avail[i]) begin
                if (CH_W'(i) >= start) begin
                    sel_hi_valid = 1'b1;
                    sel_hi       = CH_W'(i);
                end else begin
                    sel_lo_valid = 1'b1;
                    sel_lo       = CH_W'(i);
                end
            end
        end

        if (!done_valid_q || done_accept) begin
            done_valid_d = sel_hi_valid || sel_lo_valid;
            if (sel_hi_valid) begin
                done_ch_d = sel_hi;
            end else if (sel_lo_valid) begin
                done_ch_d = sel_lo;
            end
        end
    end

    // Pending flags, RR pointer and registered done outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q    <= '0;
            rr_q         <= '0;
            done_valid_q <= 1'b0;
            done_ch_q    <= '0;
        end else begin
            pending_q    <= pending_d;
            rr_q         <= rr_d;
            done_valid_q <= done_valid_d;
            done_ch_q    <= done_ch_d;
        end
    end

    assign done_valid = done_valid_q;
    assign done_ch    = done_ch_q;

`ifdef SEC_TIMER_SQWAVE_EN
    // ------------------------------------------------------------------
    localparam logic [PS_W-1:0] PS_HALF = PS_W'(TICK_DIV / 2 - 1);

    logic sq_q, sq_d;

    // Toggle at mid-period and at wrap for a 50% duty wave at the tick rate
    always_comb begin
        sq_d = sq_q;
        if (presc_q == PS_HALF || presc_q == PS_LAST) begin
            sq_d = ~sq_q;
        end
    end

    // Square-wave register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sq_q <= 1'b0;
        end else begin
            sq_q <= sq_d;
        end
    end

    assign sq_out = sq_q;
`endif

endmodule
